// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the architectural PC, issues one imem request at a time,
// and hands {instruction, PC} to decode over a valid/ready handshake with redirect squashing.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic        r_squash;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;
    logic        r_misaligned_err;

    logic        w_redirect;
    logic [31:0] w_target_pc;
    logic [31:0] w_pc_plus4;
    logic        w_req_fire;
    logic        w_target_misaligned;

    // Redirects are only honoured once the fetch loop is running.
    assign w_redirect          = redirect_valid && (r_state != S_IDLE);
    assign w_target_pc         = {redirect_target[31:2], 2'b00};
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);
    assign w_pc_plus4          = r_pc + 32'd4;
    assign w_req_fire          = imem_req_valid && imem_req_ready;

    assign imem_req_valid = (r_state == S_FETCH) && !stall;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_OUT);
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign misaligned_err = r_misaligned_err;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // branch reads the pre-edge values of r_pc/r_squash regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_pc             <= RESET_PC;
            r_squash         <= 1'b0;
            r_inst_data      <= 32'd0;
            r_inst_pc        <= 32'd0;
            r_misaligned_err <= 1'b0;
        end else begin
            r_misaligned_err <= w_redirect && w_target_misaligned;

            if (w_redirect) begin
                r_pc <= w_target_pc;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end

                S_FETCH: begin
                    // An accepted request that races a redirect must have its response dropped.
                    if (w_req_fire) begin
                        r_state  <= S_WAIT;
                        r_squash <= w_redirect;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_squash <= 1'b0;
                        if (w_redirect || r_squash) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_inst_data <= imem_rsp_data;
                            r_inst_pc   <= r_pc;
                            r_pc        <= w_pc_plus4;
                            r_state     <= S_OUT;
                        end
                    end else if (w_redirect) begin
                        r_squash <= 1'b1;
                    end
                end

                S_OUT: begin
                    // A redirect discards an undelivered instruction; a delivered one simply retires.
                    if (w_redirect || inst_ready) begin
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a per-cycle vector table for the main fetch/redirect flow
// plus hand-written sequences for decode hold, misaligned redirect, PC wrap, stall and mid-run reset.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misaligned_err;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .misaligned_err  (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] target;
        logic        stall;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        inst_ready;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_inst_valid;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t table_q[$];

    function automatic vec_t mk(input logic redir, input logic [31:0] target, input logic stl,
                                input logic rdy, input logic rspv, input logic [31:0] rspd,
                                input logic irdy, input logic erv, input logic [31:0] eaddr,
                                input logic eiv, input logic [31:0] edata, input logic [31:0] epc,
                                input logic emis);
        vec_t v;
        v.redir = redir;   v.target = target;  v.stall = stl;     v.req_ready = rdy;
        v.rsp_valid = rspv; v.rsp_data = rspd; v.inst_ready = irdy;
        v.e_req_valid = erv; v.e_addr = eaddr; v.e_inst_valid = eiv;
        v.e_data = edata;  v.e_pc = epc;       v.e_mis = emis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        redirect_valid  = v.redir;
        redirect_target = v.target;
        stall           = v.stall;
        imem_req_ready  = v.req_ready;
        imem_rsp_valid  = v.rsp_valid;
        imem_rsp_data   = v.rsp_data;
        inst_ready      = v.inst_ready;
    endtask

    task automatic check_outs(input vec_t v, input string tag);
        check({tag, ".req_valid"},  {31'd0, imem_req_valid}, {31'd0, v.e_req_valid});
        check({tag, ".req_addr"},   imem_req_addr,           v.e_addr);
        check({tag, ".inst_valid"}, {31'd0, inst_valid},     {31'd0, v.e_inst_valid});
        check({tag, ".inst_data"},  inst_data,               v.e_data);
        check({tag, ".inst_pc"},    inst_pc,                 v.e_pc);
        check({tag, ".misaligned"}, {31'd0, misaligned_err}, {31'd0, v.e_mis});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check_outs(v, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Main flow: inst_pc 0,4,8; FETCH redirect without handshake; WAIT redirect (squash);
        // FETCH redirect with handshake; WAIT redirect with simultaneous response.
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h000, 0, 0,            0,      0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000000, 1, 0, 32'h000, 0, 0,            0,      0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 0, 32'h004, 1, 32'h13000000, 0,      0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h004, 0, 32'h13000000, 0,      0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000004, 1, 0, 32'h004, 0, 32'h13000000, 0,      0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 0, 32'h008, 1, 32'h13000004, 32'h4,  0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h008, 0, 32'h13000004, 32'h4,  0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000008, 1, 0, 32'h008, 0, 32'h13000004, 32'h4,  0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 0, 32'h00C, 1, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(1, 32'h008, 0, 0, 0, 0,            1, 1, 32'h00C, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h008, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(1, 32'h100, 0, 1, 0, 0,            1, 0, 32'h008, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000008, 1, 0, 32'h100, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h100, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000100, 1, 0, 32'h100, 0, 32'h13000008, 32'h8,  0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 0, 32'h104, 1, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(1, 32'h300, 0, 1, 0, 0,            1, 1, 32'h104, 0, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000104, 1, 0, 32'h300, 0, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h300, 0, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(1, 32'h010, 0, 1, 1, 32'h13000300, 1, 0, 32'h300, 0, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(0, 0,       0, 1, 0, 0,            1, 1, 32'h010, 0, 32'h13000100, 32'h100, 0));
        table_q.push_back(mk(0, 0,       0, 1, 1, 32'h13000010, 1, 0, 32'h010, 0, 32'h13000100, 32'h100, 0));

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outs(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0), "reset");
        rst_n = 1'b1;
        #1;
        check_outs(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0), "idle");

        foreach (table_q[i]) begin
            apply(table_q[i], $sformatf("vec%0d", i));
        end

        // Decode holds off for 5 cycles: instruction at 0x10 stays put, no new request.
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h14, 1, 32'h13000010, 32'h10, 0), $sformatf("hold%0d", i));
        end
        apply(mk(0, 0, 0, 1, 0, 0,            1, 0, 32'h14, 1, 32'h13000010, 32'h10, 0), "hold_accept");
        apply(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'h14, 0, 32'h13000010, 32'h10, 0), "after_hold_req");
        apply(mk(0, 0, 0, 1, 1, 32'h13000014, 1, 0, 32'h14, 0, 32'h13000010, 32'h10, 0), "wait14");

        // Misaligned redirect while holding an undelivered instruction in OUT.
        apply(mk(1, 32'h203, 0, 1, 0, 0, 0, 0, 32'h18,  1, 32'h13000014, 32'h14, 0), "mis_redirect");
        apply(mk(0, 0,       0, 0, 0, 0, 1, 1, 32'h200, 0, 32'h13000014, 32'h14, 1), "mis_pulse");
        apply(mk(0, 0,       0, 0, 0, 0, 1, 1, 32'h200, 0, 32'h13000014, 32'h14, 0), "mis_clear");

        // Wrap: 0xFFFF_FFFC followed by 0x0000_0000.
        apply(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,            1, 1, 32'h200,       0, 32'h13000014, 32'h14,        0), "wrap_redirect");
        apply(mk(0, 0,             0, 1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'h13000014, 32'h14,        0), "wrap_req");
        apply(mk(0, 0,             0, 1, 1, 32'hDEAD0001, 1, 0, 32'hFFFF_FFFC, 0, 32'h13000014, 32'h14,        0), "wrap_wait");
        apply(mk(0, 0,             0, 1, 0, 0,            1, 0, 32'h0,         1, 32'hDEAD0001, 32'hFFFF_FFFC, 0), "wrap_out");
        apply(mk(0, 0,             0, 1, 0, 0,            1, 1, 32'h0,         0, 32'hDEAD0001, 32'hFFFF_FFFC, 0), "wrap_req0");
        apply(mk(0, 0,             0, 1, 1, 32'hDEAD0002, 1, 0, 32'h0,         0, 32'hDEAD0001, 32'hFFFF_FFFC, 0), "wrap_wait0");
        apply(mk(0, 0,             0, 1, 0, 0,            1, 0, 32'h4,         1, 32'hDEAD0002, 32'h0,         0), "wrap_out0");

        // Stall in FETCH for 4 cycles with a ready memory: no request escapes.
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, 0, 1, 1, 0, 0, 1, 0, 32'h4, 0, 32'hDEAD0002, 32'h0, 0), $sformatf("stall%0d", i));
        end
        apply(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h4, 0, 32'hDEAD0002, 32'h0, 0), "stall_release");
        apply(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h4, 0, 32'hDEAD0002, 32'h0, 0), "wait_before_reset");

        // Reset in WAIT: outputs clear immediately; the late response in IDLE is ignored.
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        check_outs(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0), "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v = mk(0, 0, 0, 0, 1, 32'hDEAD0003, 1, 0, 32'h0, 0, 0, 0, 0);
        drive(v);
        #1;
        check_outs(v, "late_rsp_idle");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0), "post_reset_fetch");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0), "post_reset_fetch2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
